uart_cmd_decoder: RTL and testbench

//  Frames and validates GUI command bytes from the UART receiver and drives the registered

---
 rtl/uart_cmd_decoder.sv | 137 +++++++++++++
 tb/tb_uart_cmd_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// rtl/uart_cmd_decoder.sv - GUI command frame decoder driving registered video selection controls
// Frames SYNC/CMD/CHK byte triples from the UART receiver, validates them,
// applies the command to registered selection outputs, abandons stalled
// frames after a byte-gap timeout and stretches reset requests into a pulse.

module uart_cmd_decoder #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         RST_PULSE_CYC  = 16
) (
  input  logic       CLK,
  input  logic       i_rst,
  input  logic [7:0] i_rx_byte,
  input  logic       i_rx_valid,
  output logic [1:0] o_img_select,
  output logic [1:0] o_res_select,
  output logic       o_out_select,
  output logic       o_pix_en,
  output logic       o_reset,
  output logic       o_cmd_valid,
  output logic       o_res_change,
  output logic       o_frame_err,
  output logic       o_timeout,
  output logic [7:0] o_cmd_byte
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RW = $clog2(RST_PULSE_CYC + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RST_LOAD = RW'(RST_PULSE_CYC);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GOT_SYNC = 2'd1,
    GOT_CMD  = 2'd2
  } state_t;

  state_t        state;
  logic [7:0]    cmd_q;
  logic [TW-1:0] to_cnt;
  logic [RW-1:0] rst_cnt;
  logic [1:0]    rst_sync;
  logic          rst_int;
  logic          frame_ok;

  // A frame is good when CHK is the bitwise inverse of CMD and the reserved bit is clear.
  assign frame_ok = (i_rx_byte == ~cmd_q) && !cmd_q[7];

  // Reset asserts immediately but releases only after two clean clock edges.
  always_ff @(posedge CLK or posedge i_rst) begin
    if (i_rst) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_int = rst_sync[1];

  // Frame FSM, byte-gap timeout, reset pulse stretcher and all registered outputs.
  always_ff @(posedge CLK or posedge rst_int) begin
    if (rst_int) begin
      state        <= IDLE;
      cmd_q        <= '0;
      to_cnt       <= '0;
      rst_cnt      <= '0;
      o_img_select <= '0;
      o_res_select <= '0;
      o_out_select <= 1'b0;
      o_pix_en     <= 1'b0;
      o_reset      <= 1'b0;
      o_cmd_valid  <= 1'b0;
      o_res_change <= 1'b0;
      o_frame_err  <= 1'b0;
      o_timeout    <= 1'b0;
      o_cmd_byte   <= '0;
    end else begin
      o_cmd_valid  <= 1'b0;
      o_res_change <= 1'b0;
      o_frame_err  <= 1'b0;
      o_timeout    <= 1'b0;

      // Count the pulse down; it drops on the edge where the count leaves 1.
      if (rst_cnt != '0) begin
        rst_cnt <= rst_cnt - 1'b1;
        o_reset <= (rst_cnt != RW'(1));
      end

      // Gap counter only runs mid-frame; any byte clears it, so a byte beats a timeout.
      if (i_rx_valid || state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        to_cnt    <= '0;
        state     <= IDLE;
        o_timeout <= 1'b1;
      end else if (to_cnt != '1) begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (i_rx_valid) begin
        case (state)
          IDLE: begin
            if (i_rx_byte == SYNC_BYTE) begin
              state <= GOT_SYNC;
            end
          end
          GOT_SYNC: begin
            cmd_q <= i_rx_byte;
            state <= GOT_CMD;
          end
          GOT_CMD: begin
            state <= IDLE;
            if (frame_ok) begin
              o_img_select <= cmd_q[1:0];
              o_res_select <= cmd_q[3:2];
              o_out_select <= cmd_q[4];
              o_pix_en     <= cmd_q[6];
              o_cmd_byte   <= cmd_q;
              o_cmd_valid  <= 1'b1;
              o_res_change <= (cmd_q[3:2] != o_res_select);
              if (cmd_q[5]) begin
                rst_cnt <= RST_LOAD;
                o_reset <= 1'b1;
              end
            end else begin
              o_frame_err <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb/tb_uart_cmd_decoder.sv - scoreboard bench for uart_cmd_decoder
module tb_uart_cmd_decoder;

  localparam int TO  = 32;
  localparam int RPC = 16;

  logic       clk;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic [1:0] img_select;
  logic [1:0] res_select;
  logic       out_select;
  logic       pix_en;
  logic       reset_o;
  logic       cmd_valid;
  logic       res_change;
  logic       frame_err;
  logic       timeout;
  logic [7:0] cmd_byte;

  uart_cmd_decoder #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TO),
    .RST_PULSE_CYC  (RPC)
  ) dut (
    .CLK          (clk),
    .i_rst        (rst),
    .i_rx_byte    (rx_byte),
    .i_rx_valid   (rx_valid),
    .o_img_select (img_select),
    .o_res_select (res_select),
    .o_out_select (out_select),
    .o_pix_en     (pix_en),
    .o_reset      (reset_o),
    .o_cmd_valid  (cmd_valid),
    .o_res_change (res_change),
    .o_frame_err  (frame_err),
    .o_timeout    (timeout),
    .o_cmd_byte   (cmd_byte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] kind;
    logic [1:0] img;
    logic [1:0] res;
    logic       out;
    logic       pix;
    logic       rc;
    logic [7:0] cmd;
  } ev_t;

  ev_t exp_q[$];
  int  rst_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  logic [1:0] m_img = '0;
  logic [1:0] m_res = '0;
  logic       m_out = 1'b0;
  logic       m_pix = 1'b0;
  logic [7:0] m_cmd = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void push_ev(logic [2:0] kind, logic rc);
    ev_t e;
    e.kind = kind; e.img = m_img; e.res = m_res; e.out = m_out;
    e.pix = m_pix; e.cmd = m_cmd; e.rc = rc;
    exp_q.push_back(e);
  endfunction

  function automatic void push_ok(logic [1:0] img, logic [1:0] res, logic out,
                                  logic pix, logic [7:0] cmd, logic rc);
    m_img = img; m_res = res; m_out = out; m_pix = pix; m_cmd = cmd;
    push_ev(3'b100, rc);
  endfunction

  task automatic send(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_img"}, 32'(img_select), 0);
    chk({tag, "_res"}, 32'(res_select), 0);
    chk({tag, "_out"}, 32'(out_select), 0);
    chk({tag, "_pix"}, 32'(pix_en), 0);
    chk({tag, "_reset"}, 32'(reset_o), 0);
    chk({tag, "_strobes"}, 32'({cmd_valid, res_change, frame_err, timeout}), 0);
    chk({tag, "_cmd_byte"}, 32'(cmd_byte), 0);
  endtask

  // Monitor: pops the scoreboard on every strobe and measures reset pulse widths.
  initial begin
    ev_t e;
    int  run;
    run = 0;
    forever begin
      @(negedge clk);
      if (cmd_valid || frame_err || timeout) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 32'({cmd_valid, frame_err, timeout}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_kind", 32'({cmd_valid, frame_err, timeout}), 32'(e.kind));
          chk("ev_img", 32'(img_select), 32'(e.img));
          chk("ev_res", 32'(res_select), 32'(e.res));
          chk("ev_out", 32'(out_select), 32'(e.out));
          chk("ev_pix", 32'(pix_en), 32'(e.pix));
          chk("ev_cmd_byte", 32'(cmd_byte), 32'(e.cmd));
          chk("ev_res_change", 32'(res_change), 32'(e.rc));
        end
      end
      if (reset_o) begin
        run++;
      end else if (run != 0) begin
        if (rst_q.size() == 0) chk("unexpected_reset_pulse", 32'(run), 0);
        else chk("reset_pulse_len", 32'(run), 32'(rst_q.pop_front()));
        run = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_byte = '0; rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    check_zero("reset");
    @(posedge clk); #1; rst = 1'b0;
    idle(4);

    // T1: valid frame, img=10 res=01 out=1
    push_ok(2'd2, 2'd1, 1'b1, 1'b0, 8'h16, 1'b1);
    send(8'hA5); send(8'h16); send(8'hE9); idle(4);

    // T2: bad checksum
    push_ev(3'b010, 1'b0);
    send(8'hA5); send(8'h16); send(8'h00); idle(4);

    // T3: reset request, re-requested 8 cycles into the pulse -> 8+16
    push_ok(2'd0, 2'd0, 1'b0, 1'b0, 8'h20, 1'b1);
    rst_q.push_back(8 + RPC);
    send(8'hA5); send(8'h20); send(8'hDF);
    idle(5);
    push_ok(2'd0, 2'd0, 1'b0, 1'b0, 8'h20, 1'b0);
    send(8'hA5); send(8'h20); send(8'hDF);
    idle(30);

    // T4: stalled frame times out, next frame accepted
    push_ev(3'b001, 1'b0);
    send(8'hA5); idle(TO + 5);
    push_ok(2'd0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0);
    send(8'hA5); send(8'h00); send(8'hFF); idle(4);

    // T5: A5 as CMD has reserved bit set
    push_ev(3'b010, 1'b0);
    send(8'hA5); send(8'hA5); send(8'h5A); idle(4);

    // Byte arriving on the timeout cycle wins
    push_ok(2'd3, 2'd2, 1'b0, 1'b1, 8'h4B, 1'b1);
    send(8'hA5); idle(TO - 1); send(8'h4B); send(8'hB4); idle(4);

    // T6: reset mid-pulse and mid-frame
    push_ok(2'd0, 2'd0, 1'b0, 1'b0, 8'h20, 1'b1);
    rst_q.push_back(2);
    send(8'hA5); send(8'h20); send(8'hDF);
    send(8'hA5); send(8'h16);
    rst = 1'b1;
    check_zero("midreset");
    m_img = '0; m_res = '0; m_out = 1'b0; m_pix = 1'b0; m_cmd = '0;
    idle(2);
    @(posedge clk); #1; rst = 1'b0;
    idle(3);
    send(8'hE9); idle(4);
    push_ok(2'd2, 2'd1, 1'b1, 1'b0, 8'h16, 1'b1);
    send(8'hA5); send(8'h16); send(8'hE9); idle(6);

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("rst_q_drained", 32'(rst_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
